// File: rtl/load_sequencer_pkg.sv
// Shared types and default constants for the load sequencer slice.
package load_seq_pkg;

    localparam int LOAD_SEQ_DATA_W = 4;
    localparam int LOAD_SEQ_DEPTH  = 4;
    localparam logic [LOAD_SEQ_DATA_W-1:0] LOAD_SEQ_TERM_VAL = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2
    } load_seq_state_e;

    // Issue is allowed in free mode, or in sync mode when the count sits at the terminal value.
    function automatic logic fire_ok(input logic sync_mode,
                                     input logic [LOAD_SEQ_DATA_W-1:0] count,
                                     input logic [LOAD_SEQ_DATA_W-1:0] term);
        return (!sync_mode) | (count == term);
    endfunction

endpackage

// File: rtl/load_sequencer_if.sv
// Valid/ready request channel carrying reload values into the load sequencer.
interface load_sequencer_if #(
    parameter int DATA_W = 4
);
    logic              req_valid_i;
    logic [DATA_W-1:0] req_val_i;
    logic              req_ready_o;

    modport master (output req_valid_i, output req_val_i, input  req_ready_o);
    modport slave  (input  req_valid_i, input  req_val_i, output req_ready_o);
endinterface

// File: rtl/load_sequencer_fifo.sv
// Synchronous FIFO holding queued reload values; occupancy is a register.
module load_seq_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int PW     = $clog2(DEPTH),
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = (count_r == CW'(DEPTH));
    assign empty    = (count_r == '0);
    assign count    = count_r;

    // Storage write; the caller guarantees no push while full.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally for a power-of-two depth.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/load_sequencer.sv
// Load sequencer: queues reload values and pulses them into a loadable counter,
// either as soon as possible or aligned to the counter's terminal value.
// Optional build macro LOAD_SEQ_FLUSH_EN adds a flush_i input that empties the queue.
module load_sequencer
    import load_seq_pkg::*;
#(
    parameter int DATA_W = LOAD_SEQ_DATA_W,
    parameter int DEPTH  = LOAD_SEQ_DEPTH,
    parameter logic [DATA_W-1:0] TERM_VAL = LOAD_SEQ_TERM_VAL
) (
    input  logic                       clk,
    input  logic                       reset,
    load_sequencer_if.slave            req,
    input  logic                       sync_mode_i,
    input  logic [DATA_W-1:0]          count_i,
`ifdef LOAD_SEQ_FLUSH_EN
    input  logic                       flush_i,
`endif
    output logic                       load_o,
    output logic [DATA_W-1:0]          load_val_o,
    output logic [$clog2(DEPTH+1)-1:0] pending_o
);

    load_seq_state_e   state_r;
    logic              flush_s;
    logic              push_s;
    logic              pop_s;
    logic              fire_s;
    logic              full_s;
    logic              empty_s;
    logic [DATA_W-1:0] head_s;

`ifdef LOAD_SEQ_FLUSH_EN
    assign flush_s = flush_i;
`else
    assign flush_s = 1'b0;
`endif

    // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot early.
    assign req.req_ready_o = reset & !full_s;
    assign push_s = req.req_valid_i & req.req_ready_o & !flush_s;
    assign fire_s = fire_ok(sync_mode_i, count_i, TERM_VAL);
    assign pop_s  = (state_r == ARMED) & fire_s & !flush_s;

    load_seq_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush_s),
        .push      (push_s),
        .push_data (req.req_val_i),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (pending_o)
    );

    // Issue FSM with registered load pulse; FIRE always returns through ARMED or IDLE,
    // which keeps pulses at least two cycles apart so the counter absorbs each load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            load_o     <= 1'b0;
            load_val_o <= '0;
        end else if (flush_s) begin
            state_r <= IDLE;
            load_o  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    load_o <= 1'b0;
                    if (push_s || !empty_s) begin
                        state_r <= ARMED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ARMED: begin
                    if (fire_s) begin
                        state_r    <= FIRE;
                        load_o     <= 1'b1;
                        load_val_o <= head_s;
                    end else begin
                        state_r <= ARMED;
                        load_o  <= 1'b0;
                    end
                end
                FIRE: begin
                    load_o <= 1'b0;
                    if (push_s || !empty_s) begin
                        state_r <= ARMED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    load_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_sequencer.sv
// Directed, table-driven bench for load_sequencer (flush cases need LOAD_SEQ_FLUSH_EN).
module tb_load_sequencer;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [3:0] val;
        logic       sync;
        logic [3:0] cnt;
        logic       e_ready;
        logic       e_load;
        logic [3:0] e_val;
        logic [2:0] e_pend;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       sync_mode_i;
    logic [3:0] count_i;
    logic       load_o;
    logic [3:0] load_val_o;
    logic [2:0] pending_o;
`ifdef LOAD_SEQ_FLUSH_EN
    logic       flush_i;
`endif

    int n_vec;
    int n_bad;
    vec_t vq[$];

    load_sequencer_if #(.DATA_W(4)) req_if ();

    load_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req_if.slave),
        .sync_mode_i (sync_mode_i),
        .count_i     (count_i),
`ifdef LOAD_SEQ_FLUSH_EN
        .flush_i     (flush_i),
`endif
        .load_o      (load_o),
        .load_val_o  (load_val_o),
        .pending_o   (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic v, logic [3:0] d, logic s, logic [3:0] c,
                                logic er, logic el, logic [3:0] ev, logic [2:0] ep);
        vec_t x;
        x.rst = r; x.valid = v; x.val = d; x.sync = s; x.cnt = c;
        x.e_ready = er; x.e_load = el; x.e_val = ev; x.e_pend = ep;
        return x;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector, check ready before the edge and registered outputs after it.
    task automatic apply(input string tag, input vec_t x);
        reset = x.rst;
        req_if.req_valid_i = x.valid;
        req_if.req_val_i = x.val;
        sync_mode_i = x.sync;
        count_i = x.cnt;
        #1;
        chk({tag, " ready"}, {7'd0, req_if.req_ready_o}, {7'd0, x.e_ready});
        @(posedge clk);
        #1;
        chk({tag, " load"}, {7'd0, load_o}, {7'd0, x.e_load});
        chk({tag, " load_val"}, {4'd0, load_val_o}, {4'd0, x.e_val});
        chk({tag, " pending"}, {5'd0, pending_o}, {5'd0, x.e_pend});
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
`ifdef LOAD_SEQ_FLUSH_EN
        flush_i = 1'b0;
`endif
        //             rst   v     val    sync  cnt    rdy   load  lval   pend
        // reset held with valid offered
        vq.push_back(mk(1'b0, 1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 3'd0));
        vq.push_back(mk(1'b0, 1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 3'd0));
        vq.push_back(mk(1'b0, 1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 3'd0));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 3'd0));
        // free mode single push of 5
        vq.push_back(mk(1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 3'd1));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h5, 3'd0));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h5, 3'd0));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h5, 3'd0));
        // sync mode, count 3: fill to full, 9 held off
        vq.push_back(mk(1'b1, 1'b1, 4'h1, 1'b1, 4'h3, 1'b1, 1'b0, 4'h5, 3'd1));
        vq.push_back(mk(1'b1, 1'b1, 4'h2, 1'b1, 4'h3, 1'b1, 1'b0, 4'h5, 3'd2));
        vq.push_back(mk(1'b1, 1'b1, 4'h3, 1'b1, 4'h3, 1'b1, 1'b0, 4'h5, 3'd3));
        vq.push_back(mk(1'b1, 1'b1, 4'h4, 1'b1, 4'h3, 1'b1, 1'b0, 4'h5, 3'd4));
        vq.push_back(mk(1'b1, 1'b1, 4'h9, 1'b1, 4'h3, 1'b0, 1'b0, 4'h5, 3'd4));
        vq.push_back(mk(1'b1, 1'b1, 4'h9, 1'b1, 4'h3, 1'b0, 1'b0, 4'h5, 3'd4));
        // count F: pulses every other cycle, 9 accepted once a slot frees
        vq.push_back(mk(1'b1, 1'b1, 4'h9, 1'b1, 4'hF, 1'b0, 1'b1, 4'h1, 3'd3));
        vq.push_back(mk(1'b1, 1'b1, 4'h9, 1'b1, 4'hF, 1'b1, 1'b0, 4'h1, 3'd4));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1, 4'h2, 3'd3));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h2, 3'd3));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b1, 4'h3, 3'd2));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h3, 3'd2));
        // push A on a pop edge with two pending
        vq.push_back(mk(1'b1, 1'b1, 4'hA, 1'b1, 4'hF, 1'b1, 1'b1, 4'h4, 3'd2));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h4, 3'd2));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b1, 4'h9, 3'd1));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h9, 3'd1));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b1, 4'hA, 3'd0));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'hA, 3'd0));
        // sync-mode drop takes effect on the next ARMED cycle
        vq.push_back(mk(1'b1, 1'b1, 4'h6, 1'b1, 4'h3, 1'b1, 1'b0, 4'hA, 3'd1));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b1, 4'h3, 1'b1, 1'b0, 4'hA, 3'd1));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h3, 1'b1, 1'b1, 4'h6, 3'd0));
        vq.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h3, 1'b1, 1'b0, 4'h6, 3'd0));

        foreach (vq[i]) begin
            apply($sformatf("vec%0d", i), vq[i]);
        end

        // Reset during the FIRE cycle truncates the pulse and clears load_val_o.
        apply("rstfire push", mk(1'b1, 1'b1, 4'hB, 1'b0, 4'h0, 1'b1, 1'b0, 4'h6, 3'd1));
        apply("rstfire fire", mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hB, 3'd0));
        apply("rstfire rst",  mk(1'b0, 1'b1, 4'hC, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 3'd0));
        apply("rstfire rel",  mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 3'd0));

`ifdef LOAD_SEQ_FLUSH_EN
        // Flush while ARMED: queue emptied, same-edge push dropped, no pulse.
        apply("flA p1", mk(1'b1, 1'b1, 4'h1, 1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 3'd1));
        apply("flA p2", mk(1'b1, 1'b1, 4'h2, 1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 3'd2));
        apply("flA p3", mk(1'b1, 1'b1, 4'h3, 1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 3'd3));
        flush_i = 1'b1;
        apply("flA flush", mk(1'b1, 1'b1, 4'h7, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 3'd0));
        flush_i = 1'b0;
        apply("flA after", mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 3'd0));
        // Flush in the FIRE cycle: the pulse completes, then IDLE and empty.
        apply("flF p4", mk(1'b1, 1'b1, 4'h4, 1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 3'd1));
        apply("flF p5", mk(1'b1, 1'b1, 4'h5, 1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 3'd2));
        apply("flF p6", mk(1'b1, 1'b1, 4'h6, 1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 3'd3));
        apply("flF fire", mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b1, 4'h4, 3'd2));
        flush_i = 1'b1;
        apply("flF flush", mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h4, 3'd0));
        flush_i = 1'b0;
        apply("flF idle1", mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h4, 3'd0));
        apply("flF idle2", mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h4, 3'd0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
